source_exec_buffer: RTL and testbench

- Elastic pipeline boundary between the operand-source stage and the execute stage.
- Holds up to two complete source bundles: 8 lanes, namely 4 ALU, 2 MEM, 1 branch and 1 mult.
- Decouples the source stage from execute back-pressure with a valid/ready handshake and supports a global pipeline flush.
- Registered ready; no combinational path from ready_in to ready_out.

---
 rtl/source_exec_buffer_pkg.sv | 32 +++
 rtl/source_exec_buffer_fifo2.sv | 68 ++++++
 rtl/source_exec_buffer.sv | 92 +++++++++
 tb/tb_source_exec_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/source_exec_buffer_pkg.sv
// source_exec_buffer_pkg
//   Shared types and constants for the source -> execute pipeline boundary.
//   Lane order within a bundle: ALU0-3, MEM0-1, BR0, MUL0 (lane 0 in the
//   least significant LANE_W bits of the flat payload bus).
package source_exec_buffer_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 192;
    localparam int unsigned CSR_W  = 64;
    localparam int unsigned DEPTH  = 2;

    localparam int unsigned ALU_BASE = 0;
    localparam int unsigned MEM_BASE = 4;
    localparam int unsigned BR_BASE  = 6;
    localparam int unsigned MUL_BASE = 7;

    typedef logic [LANE_W-1:0] lane_payload_t;

    typedef struct packed {
        logic [LANES-1:0]                lane_valid;
        lane_payload_t [LANES-1:0]       lanes;
        logic [CSR_W-1:0]                csr;
    } exec_bundle_t;

    // 32-bit counter increment that sticks at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/source_exec_buffer_fifo2.sv
// bundle_fifo2
//   Two-entry circular valid/ready FIFO of exec_bundle_t with synchronous
//   flush. No bypass: an entry is presented the cycle after it is written.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     flush           kill stored and incoming entries (highest priority)
//     in_valid/in_ready/in_data     write side; in_ready is registered-only
//     out_valid/out_ready/out_data  read side; out_data is '0 when empty
//     count           occupancy (0..2)
module bundle_fifo2
    import source_exec_buffer_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  exec_bundle_t in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output exec_bundle_t out_data,
    output logic [1:0]   count
);

    logic [1:0]   count_q;
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    exec_bundle_t mem_q [DEPTH];
    logic         enq;
    logic         deq;

    always_comb begin
        in_ready  = (count_q != 2'd2);
        enq       = in_valid & in_ready & ~flush;
        out_valid = (count_q != 2'd0) & ~flush;
        deq       = out_valid & out_ready;
        out_data  = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i].lane_valid <= '0;
            end
        end else begin
            if (enq) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, enq} - {1'b0, deq};
        end
    end

endmodule

// File: rtl/source_exec_buffer.sv
// source_exec_buffer
//   Elastic two-bundle buffer between the operand-source and execute stages.
//   Bundles with no valid lane complete the handshake but are not stored.
//   Optional macro SRC_EXEC_PERF_EN adds saturating performance counters.
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     valid_in, lane_valid_in, data_in, csr_in, ready_out   source side
//     valid_out, lane_valid_out, data_out, csr_out, ready_in execute side
//     flush                      kill all buffered and incoming bundles
//     perf_full_cycles, perf_bubble_cycles, perf_flush_drops
//                                (SRC_EXEC_PERF_EN only) 32-bit counters
module source_exec_buffer
    import source_exec_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [LANES-1:0]        lane_valid_in,
    input  logic [LANES*LANE_W-1:0] data_in,
    input  logic [CSR_W-1:0]        csr_in,
    output logic                    ready_out,
    output logic                    valid_out,
    output logic [LANES-1:0]        lane_valid_out,
    output logic [LANES*LANE_W-1:0] data_out,
    output logic [CSR_W-1:0]        csr_out,
    input  logic                    ready_in,
    input  logic                    flush
`ifdef SRC_EXEC_PERF_EN
    ,
    output logic [31:0]             perf_full_cycles,
    output logic [31:0]             perf_bubble_cycles,
    output logic [31:0]             perf_flush_drops
`endif
);

    exec_bundle_t in_bundle;
    exec_bundle_t head_bundle;
    logic [1:0]   count;
    logic         store_valid;

    always_comb begin
        in_bundle.lane_valid = lane_valid_in;
        in_bundle.lanes      = data_in;
        in_bundle.csr        = csr_in;
        // An all-empty bundle is still acknowledged through ready_out but
        // never reaches storage.
        store_valid          = valid_in & (|lane_valid_in);
    end

    bundle_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (store_valid),
        .in_ready  (ready_out),
        .in_data   (in_bundle),
        .out_valid (valid_out),
        .out_ready (ready_in),
        .out_data  (head_bundle),
        .count     (count)
    );

    always_comb begin
        lane_valid_out = head_bundle.lane_valid;
        data_out       = head_bundle.lanes;
        csr_out        = head_bundle.csr;
    end

`ifdef SRC_EXEC_PERF_EN
    logic [1:0] drop_inc;

    // Drops in a flush cycle: every held bundle plus any bundle offered.
    always_comb begin
        drop_inc = flush ? (count + {1'b0, valid_in}) : 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_full_cycles   <= '0;
            perf_bubble_cycles <= '0;
            perf_flush_drops   <= '0;
        end else begin
            perf_full_cycles   <= sat_add(perf_full_cycles,
                                          {1'b0, (count == 2'd2) & valid_in});
            perf_bubble_cycles <= sat_add(perf_bubble_cycles,
                                          {1'b0, (count == 2'd0) & ready_in});
            perf_flush_drops   <= sat_add(perf_flush_drops, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_source_exec_buffer.sv
module tb_source_exec_buffer;
    import source_exec_buffer_pkg::*;

    localparam int unsigned DW = LANES * LANE_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_in;
    logic [LANES-1:0] lane_valid_in;
    logic [DW-1:0]    data_in;
    logic [CSR_W-1:0] csr_in;
    logic             ready_out;
    logic             valid_out;
    logic [LANES-1:0] lane_valid_out;
    logic [DW-1:0]    data_out;
    logic [CSR_W-1:0] csr_out;
    logic             ready_in;
    logic             flush;
`ifdef SRC_EXEC_PERF_EN
    logic [31:0]      perf_full_cycles;
    logic [31:0]      perf_bubble_cycles;
    logic [31:0]      perf_flush_drops;
    logic [31:0]      m_full, m_bubble, m_drops;
`endif

    typedef struct {
        logic [LANES-1:0] lv;
        logic [DW-1:0]    d;
        logic [CSR_W-1:0] c;
    } bun_t;

    bun_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   outs     = 0;
    bit   pin_pc   = 1'b0;

    source_exec_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .lane_valid_in  (lane_valid_in),
        .data_in        (data_in),
        .csr_in         (csr_in),
        .ready_out      (ready_out),
        .valid_out      (valid_out),
        .lane_valid_out (lane_valid_out),
        .data_out       (data_out),
        .csr_out        (csr_out),
        .ready_in       (ready_in),
        .flush          (flush)
`ifdef SRC_EXEC_PERF_EN
        ,
        .perf_full_cycles   (perf_full_cycles),
        .perf_bubble_cycles (perf_bubble_cycles),
        .perf_flush_drops   (perf_flush_drops)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload();
        for (int i = 0; i < int'(DW / 32); i++) data_in[i*32 +: 32] = $urandom();
        csr_in = {$urandom(), $urandom()};
        if (pin_pc) data_in[63:0] = 64'h0000_0000_8000_0000;
    endtask

    task automatic reset_model();
        q.delete();
`ifdef SRC_EXEC_PERF_EN
        m_full = 0; m_bubble = 0; m_drops = 0;
`endif
    endtask

    // One clock cycle: drive at negedge, check before the posedge, then
    // advance the queue model across the edge.
    task automatic step(input logic vin, input logic [LANES-1:0] lv,
                        input logic rdy, input logic fl, input bit fresh);
        logic exp_ready, exp_valid, enq, deq;
        bun_t b;
        int   sz;
        valid_in = vin; lane_valid_in = lv; ready_in = rdy; flush = fl;
        if (fresh) new_payload();
        #1;
        sz        = q.size();
        exp_ready = (sz < 2);
        exp_valid = (sz > 0) && !fl;
        chk("ready_out", ready_out, exp_ready);
        chk("valid_out", valid_out, exp_valid);
        if (sz == 0) begin
            chk("lane_valid_empty", lane_valid_out, 0);
        end else if (!fl) begin
            chk("lane_valid_out", lane_valid_out, q[0].lv);
            chk("csr_out", csr_out, q[0].c);
            for (int i = 0; i < int'(LANES); i++)
                chk($sformatf("lane%0d", i), data_out[i*LANE_W +: LANE_W], q[0].d[i*LANE_W +: LANE_W]);
        end
`ifdef SRC_EXEC_PERF_EN
        chk("perf_full", perf_full_cycles, m_full);
        chk("perf_bubble", perf_bubble_cycles, m_bubble);
        chk("perf_drops", perf_flush_drops, m_drops);
`endif
        if (valid_out && rdy) outs++;
        enq = vin && exp_ready && !fl && (lv != 0);
        deq = exp_valid && rdy;
        b.lv = lv; b.d = data_in; b.c = csr_in;
        @(posedge clk);
`ifdef SRC_EXEC_PERF_EN
        if (sz == 2 && vin) m_full++;
        if (sz == 0 && rdy) m_bubble++;
        if (fl) m_drops += sz + (vin ? 1 : 0);
`endif
        if (fl) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(b);
        end
        @(negedge clk);
    endtask

    function automatic logic [LANES-1:0] nz_lanes();
        return LANES'($urandom_range(1, 255));
    endfunction

    initial begin
        int base;
        logic [LANES-1:0] lv;
        reset = 1'b1; valid_in = 0; lane_valid_in = '0; data_in = '0;
        csr_in = '0; ready_in = 0; flush = 0;
        reset_model();
        #12;
        chk("rst_ready_out", ready_out, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_lane_valid", lane_valid_out, 0);
        chk("rst_data_out", {128'd0, data_out[127:0]}, 0);
        chk("rst_csr_out", csr_out, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single bundle, lane ALU0 only, pc 0x8000_0000.
        pin_pc = 1'b1;
        step(1, 8'h01, 1, 0, 1);
        pin_pc = 1'b0;
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // Back-pressure: A, B stored; C held while full, then drained in order.
        step(1, nz_lanes(), 0, 0, 1);
        step(1, nz_lanes(), 0, 0, 1);
        lv = nz_lanes();
        step(1, lv, 0, 0, 1);
        step(1, lv, 0, 0, 0);
        step(1, lv, 1, 0, 0);
        step(1, lv, 1, 0, 0);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        chk("backpressure_drained", q.size(), 0);

        // Streaming 100 back-to-back bundles.
        base = outs;
        repeat (100) step(1, nz_lanes(), 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        chk("stream_count", outs - base, 100);

        // Flush with two held and one offered, then D.
        step(1, nz_lanes(), 0, 0, 1);
        step(1, nz_lanes(), 0, 0, 1);
        step(1, nz_lanes(), 0, 1, 1);
        step(1, nz_lanes(), 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // Empty-lane bundles are acknowledged but never emitted.
        step(1, 8'h00, 1, 0, 1);
        step(1, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // Asynchronous reset while full, off the clock edge.
        step(1, nz_lanes(), 0, 0, 1);
        step(1, nz_lanes(), 0, 0, 1);
        valid_in = 0;
        #2 reset = 1'b1;
        #1;
        chk("async_valid_out", valid_out, 0);
        chk("async_ready_out", ready_out, 1);
        chk("async_lane_valid", lane_valid_out, 0);
        reset_model();
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        step(1, nz_lanes(), 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // Randomized traffic with occasional empty bundles and flushes.
        repeat (400) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 8'h00 : nz_lanes(),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, 1);
        end
        repeat (3) step(0, 8'h00, 1, 0, 1);
        chk("final_empty_valid", valid_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
